// File: rtl/ppi_pkg.sv
//==============================================================================
// Module : ppi_pkg
// Brief  : Shared constants, FSM state type and read-mux helper for the PPI bus stage.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package ppi_pkg;

    localparam logic [1:0] ADDR_PA   = 2'b00;
    localparam logic [1:0] ADDR_PB   = 2'b01;
    localparam logic [1:0] ADDR_PC   = 2'b10;
    localparam logic [1:0] ADDR_CTRL = 2'b11;

    localparam logic [7:0] RESET_CW_DEFAULT = 8'h9B;

    // Control-word bit positions; a set direction bit means "input", so the
    // matching output enable is its inverse.
    localparam int CW_MODE_SET = 7;
    localparam int CW_PA_DIR   = 4;
    localparam int CW_PCH_DIR  = 3;
    localparam int CW_PB_DIR   = 1;
    localparam int CW_PCL_DIR  = 0;

    // Bit-set/reset word: D[3:1] selects the port C bit, D[0] is its new value.
    localparam int BSR_SEL_MSB = 3;
    localparam int BSR_SEL_LSB = 1;
    localparam int BSR_VAL     = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WR     = 2'd1,
        ST_COMMIT = 2'd2,
        ST_RD     = 2'd3
    } ppi_state_t;

    function automatic logic [7:0] read_mux(input logic [1:0] a,
                                            input logic [7:0] pa,
                                            input logic [7:0] pb,
                                            input logic [7:0] pc);
        case (a)
            ADDR_PA: return pa;
            ADDR_PB: return pb;
            ADDR_PC: return pc;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/ppi_bus_ctrl_if.sv
//==============================================================================
// Module : ppi_bus_ctrl_if
// Brief  : 8080-style CPU bus bundle (strobes, address, data) for the PPI.
// Rev    : 1.0
//==============================================================================
`default_nettype none

interface ppi_bus_ctrl_if;
    logic       nCs;
    logic       nRd;
    logic       nWr;
    logic [1:0] A;
    logic [7:0] D_in;
    logic [7:0] D_out;
    logic       D_oe;

    modport master (
        output nCs, nRd, nWr, A, D_in,
        input  D_out, D_oe
    );

    modport slave (
        input  nCs, nRd, nWr, A, D_in,
        output D_out, D_oe
    );
endinterface

`default_nettype wire

// File: rtl/ppi_bus_ctrl_sync.sv
//==============================================================================
// Module : ppi_sync
// Brief  : Multi-flop synchronizer for an active-low strobe; resets to the idle level 1.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module ppi_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic srst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else if (srst_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/ppi_bus_ctrl.sv
//==============================================================================
// Module : ppi_bus_ctrl
// Brief  : 8255A bus-interface/control stage: strobe sync, control word, port latches, readback.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module ppi_bus_ctrl
    import ppi_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] RESET_CW    = RESET_CW_DEFAULT
) (
    input  logic                Clk,
    input  logic                nReset,
    input  logic                Reset,
    ppi_bus_ctrl_if.slave       bus,
    input  logic [7:0]          pa_in,
    input  logic [7:0]          pb_in,
    input  logic [7:0]          pc_in,
    output logic [7:0]          controlword,
    output logic [7:0]          pa_out,
    output logic [7:0]          pb_out,
    output logic [7:0]          pc_out,
    output logic                pa_oe,
    output logic                pb_oe,
    output logic                pc_oe_hi,
    output logic                pc_oe_lo,
    output logic                wr_stb,
    output logic [1:0]          wr_addr
);

    logic ncs_s, nrd_s, nwr_s;
    logic cs_act, rd_act, wr_act;

    ppi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(Clk), .rst_n(nReset), .srst_i(Reset), .d_i(bus.nCs), .q_o(ncs_s)
    );
    ppi_sync #(.STAGES(SYNC_STAGES)) u_sync_rd (
        .clk(Clk), .rst_n(nReset), .srst_i(Reset), .d_i(bus.nRd), .q_o(nrd_s)
    );
    ppi_sync #(.STAGES(SYNC_STAGES)) u_sync_wr (
        .clk(Clk), .rst_n(nReset), .srst_i(Reset), .d_i(bus.nWr), .q_o(nwr_s)
    );

    assign cs_act = ~ncs_s;
    assign rd_act = ~nrd_s;
    assign wr_act = ~nwr_s;

    ppi_state_t state_q;
    logic [7:0] cw_q, pa_q, pb_q, pc_q;
    logic [7:0] dout_q;
    logic       doe_q;
    logic       wr_stb_q;
    logic [1:0] wr_addr_q;
    logic [1:0] cap_addr_q;
    logic [7:0] cap_data_q;

    logic [7:0] cw_d, pa_d, pb_d, pc_d;

    // Latch contents as they would be after applying the captured write.
    always_comb begin
        cw_d = cw_q;
        pa_d = pa_q;
        pb_d = pb_q;
        pc_d = pc_q;
        case (cap_addr_q)
            ADDR_PA: pa_d = cap_data_q;
            ADDR_PB: pb_d = cap_data_q;
            ADDR_PC: pc_d = cap_data_q;
            ADDR_CTRL: begin
                if (cap_data_q[CW_MODE_SET]) begin
                    cw_d = cap_data_q;
                    pa_d = 8'h00;
                    pb_d = 8'h00;
                    pc_d = 8'h00;
                end else begin
                    pc_d[cap_data_q[BSR_SEL_MSB:BSR_SEL_LSB]] = cap_data_q[BSR_VAL];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q    <= ST_IDLE;
            cw_q       <= RESET_CW;
            pa_q       <= 8'h00;
            pb_q       <= 8'h00;
            pc_q       <= 8'h00;
            dout_q     <= 8'h00;
            doe_q      <= 1'b0;
            wr_stb_q   <= 1'b0;
            wr_addr_q  <= 2'b00;
            cap_addr_q <= 2'b00;
            cap_data_q <= 8'h00;
        end else if (Reset) begin
            state_q    <= ST_IDLE;
            cw_q       <= RESET_CW;
            pa_q       <= 8'h00;
            pb_q       <= 8'h00;
            pc_q       <= 8'h00;
            dout_q     <= 8'h00;
            doe_q      <= 1'b0;
            wr_stb_q   <= 1'b0;
            wr_addr_q  <= 2'b00;
            cap_addr_q <= 2'b00;
            cap_data_q <= 8'h00;
        end else begin
            wr_stb_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cs_act && wr_act && !rd_act) begin
                        state_q    <= ST_WR;
                        cap_addr_q <= bus.A;
                        cap_data_q <= bus.D_in;
                    end else if (cs_act && rd_act && !wr_act) begin
                        state_q <= ST_RD;
                        doe_q   <= 1'b1;
                        dout_q  <= read_mux(bus.A, pa_in, pb_in, pc_in);
                    end
                end
                ST_WR: begin
                    // Losing chip-select wins over a simultaneous write release.
                    if (!cs_act) begin
                        state_q <= ST_IDLE;
                    end else if (!wr_act) begin
                        state_q   <= ST_COMMIT;
                        cw_q      <= cw_d;
                        pa_q      <= pa_d;
                        pb_q      <= pb_d;
                        pc_q      <= pc_d;
                        wr_stb_q  <= 1'b1;
                        wr_addr_q <= cap_addr_q;
                    end else begin
                        cap_addr_q <= bus.A;
                        cap_data_q <= bus.D_in;
                    end
                end
                ST_COMMIT: begin
                    if (cs_act && wr_act && !rd_act) begin
                        state_q    <= ST_WR;
                        cap_addr_q <= bus.A;
                        cap_data_q <= bus.D_in;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RD: begin
                    if (!rd_act || !cs_act) begin
                        state_q <= ST_IDLE;
                        doe_q   <= 1'b0;
                    end else begin
                        dout_q <= read_mux(bus.A, pa_in, pb_in, pc_in);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign controlword = cw_q;
    assign pa_out      = pa_q;
    assign pb_out      = pb_q;
    assign pc_out      = pc_q;
    assign pa_oe       = ~cw_q[CW_PA_DIR];
    assign pb_oe       = ~cw_q[CW_PB_DIR];
    assign pc_oe_hi    = ~cw_q[CW_PCH_DIR];
    assign pc_oe_lo    = ~cw_q[CW_PCL_DIR];
    assign wr_stb      = wr_stb_q;
    assign wr_addr     = wr_addr_q;
    assign bus.D_out   = dout_q;
    assign bus.D_oe    = doe_q;

endmodule

`default_nettype wire

// File: tb/tb_ppi_bus_ctrl.sv
//==============================================================================
// Module : tb_ppi_bus_ctrl
// Brief  : Self-checking bench for ppi_bus_ctrl against a register-level reference model.
// Rev    : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ppi_bus_ctrl;

    localparam int SYNC_STAGES = 2;
    localparam int LAT         = SYNC_STAGES + 1;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] pa_in = 8'h00, pb_in = 8'h00, pc_in = 8'h00;
    logic [7:0] controlword, pa_out, pb_out, pc_out;
    logic       pa_oe, pb_oe, pc_oe_hi, pc_oe_lo, wr_stb;
    logic [1:0] wr_addr;
    logic [35:0] dut_outs;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: the programmer-visible register file of the PPI.
    logic [7:0] m_cw;
    logic [7:0] m_port [3];

    ppi_bus_ctrl_if bus();

    ppi_bus_ctrl #(.SYNC_STAGES(SYNC_STAGES), .RESET_CW(8'h9B)) dut (
        .Clk(clk), .nReset(nreset), .Reset(reset), .bus(bus),
        .pa_in(pa_in), .pb_in(pb_in), .pc_in(pc_in),
        .controlword(controlword), .pa_out(pa_out), .pb_out(pb_out), .pc_out(pc_out),
        .pa_oe(pa_oe), .pb_oe(pb_oe), .pc_oe_hi(pc_oe_hi), .pc_oe_lo(pc_oe_lo),
        .wr_stb(wr_stb), .wr_addr(wr_addr)
    );

    always #5 clk = ~clk;

    assign dut_outs = {controlword, pa_out, pb_out, pc_out, pa_oe, pb_oe, pc_oe_hi, pc_oe_lo};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        m_cw = 8'h9B;
        for (int i = 0; i < 3; i++) m_port[i] = 8'h00;
    endfunction

    function automatic void model_write(input logic [1:0] a, input logic [7:0] d);
        int bitn;
        if (a != 2'b11) begin
            m_port[int'(a)] = d;
        end else if (d[7]) begin
            m_cw = d;
            for (int i = 0; i < 3; i++) m_port[i] = 8'h00;
        end else begin
            bitn = int'(d[3:1]);
            m_port[2][bitn] = d[0];
        end
    endfunction

    function automatic logic [35:0] model_outs();
        return {m_cw, m_port[0], m_port[1], m_port[2], !m_cw[4], !m_cw[1], !m_cw[3], !m_cw[0]};
    endfunction

    function automatic logic [7:0] model_read(input logic [1:0] a);
        if (a == 2'b00) return pa_in;
        if (a == 2'b01) return pb_in;
        if (a == 2'b10) return pc_in;
        return 8'hFF;
    endfunction

    task automatic bus_idle();
        bus.nCs = 1'b1;
        bus.nRd = 1'b1;
        bus.nWr = 1'b1;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [7:0] d, input string tag);
        int n = 0;
        int extra = 0;
        bus.A = a; bus.D_in = d; bus.nCs = 1'b0; bus.nWr = 1'b0;
        repeat (LAT + 2) tick();
        bus.nWr = 1'b1;
        do begin tick(); n++; end while (!wr_stb && n < 20);
        model_write(a, d);
        n_cmp++;
        if (n != LAT) begin n_fail++; $display("FAIL %s commit latency: got %0d want %0d", tag, n, LAT); end
        n_cmp++;
        if (wr_addr !== a) begin n_fail++; $display("FAIL %s wr_addr: got %b want %b", tag, wr_addr, a); end
        bus.nCs = 1'b1;
        repeat (LAT + 2) begin tick(); if (wr_stb) extra++; end
        n_cmp++;
        if (extra != 0) begin n_fail++; $display("FAIL %s wr_stb extra pulses: got %0d want 0", tag, extra); end
        n_cmp++;
        if (dut_outs !== model_outs())
            begin n_fail++; $display("FAIL %s outputs: got %h want %h", tag, dut_outs, model_outs()); end
    endtask

    task automatic do_read(input logic [1:0] a, input string tag);
        int n = 0;
        bus.A = a; bus.nCs = 1'b0; bus.nRd = 1'b0;
        do begin tick(); n++; end while (!bus.D_oe && n < 20);
        n_cmp++;
        if (n != LAT) begin n_fail++; $display("FAIL %s D_oe latency: got %0d want %0d", tag, n, LAT); end
        n_cmp++;
        if (bus.D_out !== model_read(a))
            begin n_fail++; $display("FAIL %s D_out: got %h want %h", tag, bus.D_out, model_read(a)); end
        bus_idle();
        n = 0;
        do begin tick(); n++; end while (bus.D_oe && n < 20);
        n_cmp++;
        if (n != LAT) begin n_fail++; $display("FAIL %s D_oe release: got %0d want %0d", tag, n, LAT); end
        repeat (2) tick();
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        repeat (3) tick();
        model_reset();
        n_cmp++;
        if ({dut_outs, bus.D_oe, bus.D_out, wr_stb, wr_addr} !== {model_outs(), 1'b0, 8'h00, 1'b0, 2'b00})
            begin n_fail++; $display("FAIL nreset state: got %h/%b/%h want %h/0/00", dut_outs, bus.D_oe, bus.D_out, model_outs()); end
        nreset = 1'b1;
        repeat (3) tick();
        do_write(2'b00, 8'h11, "pre_reset_wr");
        pb_in = 8'h6D;
        do_read(2'b01, "pre_reset_rd");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        n_cmp++;
        if ({dut_outs, bus.D_oe, bus.D_out, wr_stb} !== {model_outs(), 1'b0, 8'h00, 1'b0})
            begin n_fail++; $display("FAIL sync reset state: got %h/%b/%h want %h/0/00", dut_outs, bus.D_oe, bus.D_out, model_outs()); end
        repeat (3) tick();
    endtask

    task automatic test_write();
        do_write(2'b11, 8'h80, "mode_80");
        do_write(2'b00, 8'hA5, "pa_A5");
        n_cmp++;
        if (pa_oe !== 1'b1) begin n_fail++; $display("FAIL pa_oe after mode 80: got %b want 1", pa_oe); end
    endtask

    task automatic test_bsr();
        do_write(2'b11, 8'h80, "bsr_clear");
        do_write(2'b11, 8'h0F, "bsr_set7");
        do_write(2'b11, 8'h07, "bsr_set3");
        do_write(2'b11, 8'h06, "bsr_clr3");
        n_cmp++;
        if (controlword !== 8'h80) begin n_fail++; $display("FAIL bsr cw: got %h want 80", controlword); end
    endtask

    task automatic test_read();
        pb_in = 8'h3C;
        do_read(2'b01, "rd_pb");
        do_read(2'b11, "rd_ctrl");
        pa_in = 8'($urandom);
        pc_in = 8'($urandom);
        do_read(2'b00, "rd_pa");
        do_read(2'b10, "rd_pc");
    endtask

    task automatic test_abort();
        int pulses = 0;
        bus.A = 2'b00; bus.D_in = 8'h5A; bus.nCs = 1'b0; bus.nWr = 1'b0;
        repeat (LAT + 2) tick();
        bus.nCs = 1'b1;
        repeat (2) tick();
        bus.nWr = 1'b1;
        repeat (LAT + 4) begin tick(); if (wr_stb) pulses++; end
        n_cmp++;
        if (pulses != 0 || dut_outs !== model_outs())
            begin n_fail++; $display("FAIL cs_abort: pulses %0d outs %h want 0 / %h", pulses, dut_outs, model_outs()); end
        bus.A = 2'b01; bus.D_in = 8'h77; bus.nCs = 1'b0; bus.nWr = 1'b0;
        repeat (LAT + 2) tick();
        nreset = 1'b0;
        #2;
        bus_idle();
        tick();
        nreset = 1'b1;
        model_reset();
        pulses = 0;
        repeat (LAT + 4) begin tick(); if (wr_stb) pulses++; end
        n_cmp++;
        if (pulses != 0 || dut_outs !== model_outs())
            begin n_fail++; $display("FAIL reset_abort: pulses %0d outs %h want 0 / %h", pulses, dut_outs, model_outs()); end
        do_read(2'b11, "rd_after_abort");
    endtask

    task automatic test_mode_clear();
        do_write(2'b00, 8'h55, "pa_55");
        do_write(2'b11, 8'h9B, "mode_9B");
        n_cmp++;
        if (pa_out !== 8'h00) begin n_fail++; $display("FAIL mode clears pa_out: got %h want 00", pa_out); end
    endtask

    task automatic test_illegal();
        int pulses = 0;
        int oes = 0;
        do_write(2'b10, 8'hC3, "pc_C3");
        bus.A = 2'b00; bus.D_in = 8'hEE;
        bus.nCs = 1'b0; bus.nRd = 1'b0; bus.nWr = 1'b0;
        repeat (LAT + 4) begin tick(); if (wr_stb) pulses++; if (bus.D_oe) oes++; end
        bus_idle();
        repeat (LAT + 2) begin tick(); if (wr_stb) pulses++; if (bus.D_oe) oes++; end
        n_cmp++;
        if (pulses != 0 || oes != 0 || dut_outs !== model_outs())
            begin n_fail++; $display("FAIL illegal strobes: stb %0d oe %0d outs %h want 0/0/%h", pulses, oes, dut_outs, model_outs()); end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        bus.A = 2'b01; bus.D_in = 8'h3E; bus.nCs = 1'b0; bus.nWr = 1'b0;
        repeat (LAT + 2) tick();
        bus.nWr = 1'b1;
        tick(); n++;
        bus.nWr = 1'b0;
        while (!wr_stb && n < 20) begin tick(); n++; end
        model_write(2'b01, 8'h3E);
        n_cmp++;
        if (n != LAT || pb_out !== m_port[1])
            begin n_fail++; $display("FAIL b2b first: lat %0d pb %h want %0d/%h", n, pb_out, LAT, m_port[1]); end
        bus.A = 2'b10; bus.D_in = 8'hB7;
        repeat (LAT + 1) tick();
        bus.nWr = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!wr_stb && n < 20);
        model_write(2'b10, 8'hB7);
        n_cmp++;
        if (n != LAT || wr_addr !== 2'b10 || dut_outs !== model_outs())
            begin n_fail++; $display("FAIL b2b second: lat %0d addr %b outs %h want %0d/10/%h", n, wr_addr, dut_outs, LAT, model_outs()); end
        bus_idle();
        repeat (LAT + 2) tick();
    endtask

    task automatic test_random();
        logic [1:0] a;
        logic [7:0] d;
        for (int i = 0; i < 30; i++) begin
            a = 2'($urandom_range(0, 3));
            d = 8'($urandom);
            pa_in = 8'($urandom); pb_in = 8'($urandom); pc_in = 8'($urandom);
            if ($urandom_range(0, 1) == 0) do_write(a, d, "rand_wr");
            else do_read(a, "rand_rd");
        end
    endtask

    initial begin
        bus.A = 2'b00;
        bus.D_in = 8'h00;
        bus_idle();
        model_reset();
        test_reset();
        test_write();
        test_bsr();
        test_read();
        test_abort();
        test_mode_clear();
        test_illegal();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
